// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - parametrised UART transmitter with input FIFO and frame-aligned bit timer
module uart_tx_framer #(
  parameter int CLK_DIV    = 5208,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int BW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLK_DIV - 2);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("uart_tx_framer: CLK_DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_framer: DATA_BITS must be 5..8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_framer: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_framer: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx_framer: FIFO_DEPTH must be a power of 2, >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               r_state;
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic [BW-1:0]        r_baud;
  logic [2:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_done;

  logic                 w_full;
  logic                 w_push;
  logic                 w_slot_end;
  logic                 w_stop_end;
  logic                 w_pop;
  logic [DATA_BITS-1:0] w_head;
  logic                 w_head_par;

  // Full is decoded from the registered count, so a same-cycle pop never frees a slot early.
  assign w_full     = (r_count == DEPTH_C);
  assign w_push     = s_valid && !w_full;
  assign w_slot_end = (r_baud == BAUD_LAST);
  assign w_stop_end = (r_state == S_STOP) && w_slot_end && (r_bit == STOP_LAST);
  assign w_pop      = (r_count != '0) && ((r_state == S_IDLE) || w_stop_end);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_head_par = (PARITY == 2) ? ~^w_head : ^w_head;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Pop overrides the state case: it restarts the bit timer so every slot edge is frame-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == S_STOP) && (r_bit == STOP_LAST) && (r_baud == BAUD_PRE);
      if (w_pop) begin
        r_state <= S_START;
        r_baud  <= '0;
        r_bit   <= '0;
        r_shift <= w_head;
        r_par   <= w_head_par;
        r_tx    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_tx   <= 1'b1;
            r_baud <= '0;
          end
          S_START: begin
            if (w_slot_end) begin
              r_baud  <= '0;
              r_bit   <= '0;
              r_state <= S_DATA;
              r_tx    <= r_shift[0];
            end else begin
              r_baud <= r_baud + BW'(1);
            end
          end
          S_DATA: begin
            if (w_slot_end) begin
              r_baud <= '0;
              if (r_bit == DATA_LAST) begin
                r_bit <= '0;
                if (PARITY != 0) begin
                  r_state <= S_PARITY;
                  r_tx    <= r_par;
                end else begin
                  r_state <= S_STOP;
                  r_tx    <= 1'b1;
                end
              end else begin
                r_bit   <= r_bit + 3'd1;
                r_shift <= r_shift >> 1;
                r_tx    <= r_shift[1];
              end
            end else begin
              r_baud <= r_baud + BW'(1);
            end
          end
          S_PARITY: begin
            if (w_slot_end) begin
              r_baud  <= '0;
              r_bit   <= '0;
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_baud <= r_baud + BW'(1);
            end
          end
          S_STOP: begin
            r_tx <= 1'b1;
            if (w_slot_end) begin
              r_baud <= '0;
              if (r_bit == STOP_LAST) begin
                r_bit   <= '0;
                r_state <= S_IDLE;
              end else begin
                r_bit <= r_bit + 3'd1;
              end
            end else begin
              r_baud <= r_baud + BW'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_baud  <= '0;
          end
        endcase
      end
    end
  end

  assign s_ready    = !w_full;
  assign tx         = r_tx;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - directed self-checking bench for uart_tx_framer
module tb_uart_tx_framer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] d8 = '0, de = '0, dod = '0;
  logic [4:0] d5 = '0;
  logic v8 = 0, ve = 0, vo = 0, v5 = 0;
  logic rdy8, rdye, rdyo, rdy5;
  logic tx8, txe, txo, tx5;
  logic busy8, busye, busyo, busy5;
  logic done8, donee, doneo, done5;
  logic [2:0] cnt8, cnte, cnto, cnt5;

  uart_tx_framer #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .s_data(d8), .s_valid(v8), .s_ready(rdy8),
    .tx(tx8), .busy(busy8), .done(done8), .fifo_count(cnt8));

  uart_tx_framer #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_even (
    .clk(clk), .rst_n(rst_n), .s_data(de), .s_valid(ve), .s_ready(rdye),
    .tx(txe), .busy(busye), .done(donee), .fifo_count(cnte));

  uart_tx_framer #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_odd (
    .clk(clk), .rst_n(rst_n), .s_data(dod), .s_valid(vo), .s_ready(rdyo),
    .tx(txo), .busy(busyo), .done(doneo), .fifo_count(cnto));

  uart_tx_framer #(.CLK_DIV(4), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_5n2 (
    .clk(clk), .rst_n(rst_n), .s_data(d5), .s_valid(v5), .s_ready(rdy5),
    .tx(tx5), .busy(busy5), .done(done5), .fifo_count(cnt5));

  logic [7:0] words [6] = '{8'h3C, 8'h81, 8'hFF, 8'h00, 8'h96, 8'h5A};

  function automatic logic b2b_bit(int k);
    int f = (k - 1) / 40;
    int s = ((k - 1) % 40) / 4;
    logic [7:0] w = words[f];
    if (s == 0) return 1'b0;
    if (s == 9) return 1'b1;
    return w[s-1];
  endfunction

  task automatic test_reset;
    @(negedge clk);
    checks++; if (tx8 !== 1'b1 || txe !== 1'b1 || txo !== 1'b1 || tx5 !== 1'b1) begin failures++;
      $display("FAIL reset_tx got=%b%b%b%b exp=1111", tx8, txe, txo, tx5); end
    checks++; if (busy8 !== 1'b0 || busy5 !== 1'b0) begin failures++;
      $display("FAIL reset_busy got=%b%b exp=00", busy8, busy5); end
    checks++; if (cnt8 !== 3'd0 || cnt5 !== 3'd0 || done8 !== 1'b0) begin failures++;
      $display("FAIL reset_count got=%0d/%0d done=%b exp=0/0 done=0", cnt8, cnt5, done8); end
    checks++; if (rdy8 !== 1'b1 || rdy5 !== 1'b1) begin failures++;
      $display("FAIL reset_ready got=%b%b exp=11", rdy8, rdy5); end
    @(posedge clk); #1; rst_n = 1'b1;
    // two words queued so that reset must also flush the FIFO
    @(posedge clk); #1; v8 = 1'b1; d8 = 8'hA5;
    @(posedge clk); #1; d8 = 8'h3C;
    @(posedge clk); #1; v8 = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    checks++; if (tx8 !== 1'b0 || busy8 !== 1'b1 || cnt8 !== 3'd1) begin failures++;
      $display("FAIL midframe_pre got tx=%b busy=%b cnt=%0d exp tx=0 busy=1 cnt=1", tx8, busy8, cnt8); end
    rst_n = 1'b0;
    #1;
    checks++; if (tx8 !== 1'b1 || busy8 !== 1'b0 || cnt8 !== 3'd0 || rdy8 !== 1'b1 || done8 !== 1'b0) begin failures++;
      $display("FAIL midframe_reset got tx=%b busy=%b cnt=%0d rdy=%b done=%b exp 1 0 0 1 0", tx8, busy8, cnt8, rdy8, done8); end
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++; if (tx8 !== 1'b1 || busy8 !== 1'b0 || cnt8 !== 3'd0) begin failures++;
        $display("FAIL post_reset_idle cyc=%0d got tx=%b busy=%b cnt=%0d exp 1 0 0", i, tx8, busy8, cnt8); end
    end
  endtask

  task automatic test_frame_8n1;
    logic [9:0] exp_bits = {1'b1, 8'hA5, 1'b0};
    @(posedge clk); #1; v8 = 1'b1; d8 = 8'hA5;
    @(posedge clk); #1; v8 = 1'b0; d8 = 8'hFF;
    @(negedge clk);
    checks++; if (tx8 !== 1'b1 || cnt8 !== 3'd1 || busy8 !== 1'b0) begin failures++;
      $display("FAIL push_latency got tx=%b cnt=%0d busy=%b exp 1 1 0", tx8, cnt8, busy8); end
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      if (k <= 40) begin
        checks++; if (tx8 !== exp_bits[(k-1)/4]) begin failures++;
          $display("FAIL frame8n1_tx k=%0d got=%b exp=%b", k, tx8, exp_bits[(k-1)/4]); end
        checks++; if (done8 !== (k == 40) || busy8 !== 1'b1) begin failures++;
          $display("FAIL frame8n1_done k=%0d got done=%b busy=%b exp done=%b busy=1", k, done8, busy8, (k == 40)); end
      end else begin
        checks++; if (busy8 !== 1'b0 || tx8 !== 1'b1 || done8 !== 1'b0) begin failures++;
          $display("FAIL frame8n1_end got busy=%b tx=%b done=%b exp 0 1 0", busy8, tx8, done8); end
      end
    end
  endtask

  task automatic test_parity;
    logic [10:0] exp_e = {1'b1, 1'b1, 8'h07, 1'b0};
    logic [10:0] exp_o = {1'b1, 1'b0, 8'h07, 1'b0};
    @(posedge clk); #1; ve = 1'b1; vo = 1'b1; de = 8'h07; dod = 8'h07;
    @(posedge clk); #1; ve = 1'b0; vo = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k <= 44) begin
        checks++; if (txe !== exp_e[(k-1)/4]) begin failures++;
          $display("FAIL parity_even_tx k=%0d got=%b exp=%b", k, txe, exp_e[(k-1)/4]); end
        checks++; if (txo !== exp_o[(k-1)/4]) begin failures++;
          $display("FAIL parity_odd_tx k=%0d got=%b exp=%b", k, txo, exp_o[(k-1)/4]); end
        checks++; if (donee !== (k == 44) || doneo !== (k == 44)) begin failures++;
          $display("FAIL parity_done k=%0d got=%b%b exp=%b", k, donee, doneo, (k == 44)); end
      end else begin
        checks++; if (busye !== 1'b0 || busyo !== 1'b0) begin failures++;
          $display("FAIL parity_end_busy got=%b%b exp=00", busye, busyo); end
      end
    end
  endtask

  task automatic test_5n2;
    logic [7:0] exp_bits = {2'b11, 5'h13, 1'b0};
    @(posedge clk); #1; v5 = 1'b1; d5 = 5'h13;
    @(posedge clk); #1; v5 = 1'b0; d5 = 5'h00;
    @(negedge clk);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k <= 32) begin
        checks++; if (tx5 !== exp_bits[(k-1)/4] || busy5 !== 1'b1) begin failures++;
          $display("FAIL frame5n2_tx k=%0d got tx=%b busy=%b exp tx=%b busy=1", k, tx5, busy5, exp_bits[(k-1)/4]); end
        checks++; if (done5 !== (k == 32)) begin failures++;
          $display("FAIL frame5n2_done k=%0d got=%b exp=%b", k, done5, (k == 32)); end
      end else begin
        checks++; if (busy5 !== 1'b0 || tx5 !== 1'b1) begin failures++;
          $display("FAIL frame5n2_end got busy=%b tx=%b exp 0 1", busy5, tx5); end
      end
    end
  endtask

  task automatic test_back_to_back;
    int idx = 0;
    int dones = 0;
    logic acc;
    int exp_cnt;
    @(posedge clk); #1; v8 = 1'b1; d8 = words[0];
    for (int c = 1; c <= 246; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 6) begin
        exp_cnt = (c <= 3) ? 1 : c - 2;
        checks++; if (cnt8 !== 3'(exp_cnt)) begin failures++;
          $display("FAIL fill_count c=%0d got=%0d exp=%0d", c, cnt8, exp_cnt); end
      end
      if (c >= 6 && c <= 42) begin
        checks++; if (rdy8 !== 1'b0 || cnt8 !== 3'd4) begin failures++;
          $display("FAIL full_hold c=%0d got rdy=%b cnt=%0d exp rdy=0 cnt=4", c, rdy8, cnt8); end
      end
      if (c == 42) begin
        checks++; if (idx !== 5) begin failures++;
          $display("FAIL accepted_while_full got=%0d exp=5", idx); end
      end
      if (c == 43) begin
        checks++; if (cnt8 !== 3'd3 || rdy8 !== 1'b1) begin failures++;
          $display("FAIL pop_no_push got cnt=%0d rdy=%b exp cnt=3 rdy=1", cnt8, rdy8); end
      end
      if (c == 44) begin
        checks++; if (cnt8 !== 3'd4) begin failures++;
          $display("FAIL push_after_pop got=%0d exp=4", cnt8); end
      end
      if (c >= 3 && c <= 242) begin
        checks++; if (tx8 !== b2b_bit(c - 2) || busy8 !== 1'b1) begin failures++;
          $display("FAIL b2b_tx k=%0d got tx=%b busy=%b exp tx=%b busy=1", c - 2, tx8, busy8, b2b_bit(c - 2)); end
        checks++; if (done8 !== ((c - 2) % 40 == 0)) begin failures++;
          $display("FAIL b2b_done k=%0d got=%b exp=%b", c - 2, done8, ((c - 2) % 40 == 0)); end
        if (done8 === 1'b1) dones++;
      end
      if (c >= 243) begin
        checks++; if (busy8 !== 1'b0 || tx8 !== 1'b1 || cnt8 !== 3'd0) begin failures++;
          $display("FAIL b2b_idle c=%0d got busy=%b tx=%b cnt=%0d exp 0 1 0", c, busy8, tx8, cnt8); end
      end
      acc = v8 && rdy8;
      @(posedge clk); #1;
      if (acc) idx++;
      v8 = (idx < 6);
      d8 = (idx < 6) ? words[idx] : 8'h00;
    end
    checks++; if (dones !== 6 || idx !== 6) begin failures++;
      $display("FAIL b2b_totals got dones=%0d accepted=%0d exp 6 6", dones, idx); end
  endtask

  initial begin
    test_reset();
    test_frame_8n1();
    test_parity();
    test_5n2();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
